mmu_lsu: RTL and testbench
==========================

# mmu_lsu

Parametrised load/store memory unit between the CU and the on-chip SRAM, successor to the first-generation MMU. Accepts one CU request at a time and converts the byte address into an SRAM word index plus byte lanes. Generates single-cycle read/write pulses, waits a configurable SRAM read latency, and aligns and extends sub-word data. Flags misaligned and out-of-range accesses without touching the SRAM, and honours CU stall/flush.

## Interface
- ADDR_W, 32, CU byte-address width
- SRAM_DEPTH, 128, SRAM depth in 32-bit words; SRAM_AW = $clog2(SRAM_DEPTH)
- SRAM_LAT, 1, cycles from read_pulse to valid SRAM_dat_out (≥1)
- soc_clk  in  1  clock; all logic on rising edge
- soc_rst  in  1  synchronous, active-high reset
- MMU_stall  in  1  CU stall
- MMU_flush  in  1  abort current request
- CU_req  in  1  request strobe, sampled only in IDLE
- CU_we  in  1  0 = read, 1 = write
- CU_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- CU_unsigned  in  1  1 = zero-extend reads, 0 = sign-extend
- CU_address  in  ADDR_W  byte address
- CU_dat_in  in  32  write data, right-justified
- CU_dat_out  out  32  read result, right-justified and extended
- MMU_ready  out  1  one-cycle completion (held during stall)
- MMU_misalign  out  1  error qualifier, valid with MMU_ready
- MMU_oob  out  1  error qualifier, valid with MMU_ready
- SRAM_addr_sel  out  SRAM_AW  word index
- SRAM_byte_sel  out  4  byte-lane enables
- SRAM_dat_in  out  32  lane-aligned write data to SRAM
- SRAM_dat_out  in  32  read data from SRAM
- read_pulse  out  1  one-cycle SRAM read strobe
- write_pulse  out  1  one-cycle SRAM write strobe

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- **Capture (IDLE, CU_req=1, MMU_stall=0):** register all CU_* inputs, then compute the access checks.
  - off = address[1:0]
  - word = address[ADDR_W-1:2]
  - misalign = (half & off[0]) | (word access & off≠0) | size==11
  - oob = word ≥ SRAM_DEPTH
- **Capture with an error:** either flag set goes directly to DONE. No SRAM pulse is issued.
- **Capture without an error:** go to ISSUE.
- **Lane mask:** byte 0001, half 0011, word 1111, each shifted left by off. SRAM_byte_sel is driven with this mask.
- **Write data:** SRAM_dat_in = CU_dat_in << (8·off), truncated to 32 bits. SRAM_addr_sel = word[SRAM_AW-1:0].
- **ISSUE state:**
  - Asserts read_pulse or write_pulse (per we) for exactly one cycle, unless MMU_stall=1; a stalled ISSUE defers the pulse and holds the state.
  - A write then goes to DONE.
  - A read then goes to WAIT and loads a counter with SRAM_LAT-1.
- **WAIT state:**
  - The counter decrements each cycle.
  - MMU_stall is ignored in WAIT, because the SRAM returns data regardless.
  - When the counter reaches 0, capture (SRAM_dat_out >> 8·off), then go to DONE.
- **Read extension:** byte extends from bit 7 and half from bit 15, sign-extended or zero-extended per CU_unsigned. A word read is passed through unchanged.
- **DONE state:**
  - MMU_ready=1. CU_dat_out is updated only for successful reads.
  - CU_dat_out holds its value otherwise, including after writes and errors.
  - MMU_misalign and MMU_oob are driven with their captured values in DONE and forced to 0 elsewhere.
  - If MMU_stall=1, remain in DONE with ready held high; otherwise return to IDLE.
- **Flush:** MMU_flush=1 in any state forces IDLE at the next edge, with no ready.
  - A pulse issued in the same cycle as the flush still occurs, so the SRAM write commits.
  - Flush has priority over stall and over CU_req.
- **Busy requests:** CU_req outside IDLE is ignored and not queued.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0. CU_dat_out is cleared to 0x0000_0000.
- **Reset vs. flush:** reset has priority over flush.
- **Cycle numbering:** cycle 0 is the cycle in which CU_req is sampled.
- **Write, no stall:** pulse in cycle 1, MMU_ready in cycle 2.
- **Read, no stall:** pulse in cycle 1, data sampled at the end of cycle 1+SRAM_LAT, MMU_ready and valid CU_dat_out in cycle 2+SRAM_LAT.
- **Error:** MMU_ready with flag in cycle 1. read_pulse and write_pulse stay 0 throughout.
- **Stall cost:** each stalled cycle in ISSUE adds one cycle of latency.
- **Pulse properties:** pulses are never wider than one cycle. read_pulse and write_pulse are never high simultaneously. At most one pulse is issued per request.
- **SRAM drive hold:** SRAM_addr_sel, SRAM_byte_sel and SRAM_dat_in are stable from ISSUE until DONE exits.
- **Back-to-back requests:** minimum 1 idle cycle between requests, because CU_req is sampled only in IDLE.

## Test plan
- **Word write:** write word 0xDEADBEEF to address 0x10 -> write_pulse in cycle 1, addr_sel=4, byte_sel=1111, dat_in=0xDEADBEEF; MMU_ready in cycle 2.
- **Byte reads with extension (SRAM_LAT=2, SRAM word 4 = 0x80FF7F01):**
  - Signed byte read at address 0x13 -> byte_sel=1000; CU_dat_out=0xFFFFFF80 in cycle 4.
  - Unsigned read of the same byte -> CU_dat_out=0x00000080.
- **Halfword write:** half write of 0x1234 at address 0x22 -> byte_sel=1100, dat_in=0x12340000, addr_sel=8.
- **Error cases:**
  - Half access at address 0x01 -> MMU_ready and MMU_misalign in cycle 1, no pulse.
  - Word access at address 0x200 (DEPTH=128) -> MMU_oob in cycle 1, no pulse.
- **Stall:** hold stall for 3 cycles at ISSUE, then release -> pulse in cycle 4. Stall asserted in DONE -> ready stays high until release.
- **Flush and reset:**
  - Flush in WAIT -> IDLE next cycle, no ready, CU_dat_out unchanged.
  - Reset mid-read -> all outputs 0 on the next cycle.
  - CU_req asserted during WAIT -> ignored.

Source files
------------

// File: rtl/mmu_lsu.sv
// mmu_lsu: single-request load/store unit between the CU and a word-organised SRAM.
// Splits byte addresses into word index and lane mask, pulses the SRAM, then aligns and extends read data.
module mmu_lsu #(
    parameter int ADDR_W     = 32,
    parameter int SRAM_DEPTH = 128,
    parameter int SRAM_LAT   = 1,
    localparam int SRAM_AW   = $clog2(SRAM_DEPTH)
) (
    input  logic               soc_clk,
    input  logic               soc_rst,
    input  logic               MMU_stall,
    input  logic               MMU_flush,
    input  logic               CU_req,
    input  logic               CU_we,
    input  logic [1:0]         CU_size,
    input  logic               CU_unsigned,
    input  logic [ADDR_W-1:0]  CU_address,
    input  logic [31:0]        CU_dat_in,
    output logic [31:0]        CU_dat_out,
    output logic               MMU_ready,
    output logic               MMU_misalign,
    output logic               MMU_oob,
    output logic [SRAM_AW-1:0] SRAM_addr_sel,
    output logic [3:0]         SRAM_byte_sel,
    output logic [31:0]        SRAM_dat_in,
    input  logic [31:0]        SRAM_dat_out,
    output logic               read_pulse,
    output logic               write_pulse
);
    localparam int CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_C  = ADDR_W'(SRAM_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SRAM_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t            state_r, state_nx, fsm_nx;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_r, uns_r, mis_r, oob_r;
    logic [1:0]        size_r, off_r;
    logic [ADDR_W-1:0] word_s;
    logic [1:0]        off_s;
    logic [3:0]        mask_s;
    logic              mis_s, oob_s, capture_s, data_done_s;

    // Sign- or zero-extend a right-justified sub-word read; size 11 never reaches here.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{raw[7] & ~uns}}, raw[7:0]};
            2'b01:   res = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign word_s      = {2'b00, CU_address[ADDR_W-1:2]};
    assign off_s       = CU_address[1:0];
    assign oob_s       = (word_s >= DEPTH_C);
    assign capture_s   = (state_r == IDLE) & CU_req & ~MMU_stall & ~MMU_flush;
    assign data_done_s = (state_r == WAIT) & (cnt_r == CNT_ZERO) & ~MMU_flush;

    assign MMU_ready    = (state_r == DONE);
    assign MMU_misalign = (state_r == DONE) & mis_r;
    assign MMU_oob      = (state_r == DONE) & oob_r;

    // Lane mask and alignment check for the request presented on the CU inputs.
    always_comb begin
        mask_s = 4'b0000;
        mis_s  = 1'b1;
        case (CU_size)
            2'b00:   begin mask_s = 4'b0001 << off_s; mis_s = 1'b0;               end
            2'b01:   begin mask_s = 4'b0011 << off_s; mis_s = off_s[0];           end
            2'b10:   begin mask_s = 4'b1111 << off_s; mis_s = (off_s != 2'b00);   end
            default: begin mask_s = 4'b0000;          mis_s = 1'b1;               end
        endcase
    end

    // State register.
    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and SRAM strobe decode; a stalled ISSUE holds and defers its pulse.
    always_comb begin
        fsm_nx      = state_r;
        read_pulse  = 1'b0;
        write_pulse = 1'b0;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    fsm_nx = (mis_s | oob_s) ? DONE : ISSUE;
                end else begin
                    fsm_nx = IDLE;
                end
            end
            ISSUE: begin
                if (MMU_stall) begin
                    fsm_nx = ISSUE;
                end else if (we_r) begin
                    write_pulse = 1'b1;
                    fsm_nx      = DONE;
                end else begin
                    read_pulse = 1'b1;
                    fsm_nx     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    fsm_nx = DONE;
                end else begin
                    fsm_nx = WAIT;
                end
            end
            DONE: begin
                if (MMU_stall) begin
                    fsm_nx = DONE;
                end else begin
                    fsm_nx = IDLE;
                end
            end
            default: fsm_nx = IDLE;
        endcase
        state_nx = MMU_flush ? IDLE : fsm_nx;
    end

    // Read-latency counter, loaded as the read strobe fires.
    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            cnt_r <= CNT_ZERO;
        end else if (read_pulse) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture, SRAM drive registers and read-data return.
    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            we_r          <= 1'b0;
            uns_r         <= 1'b0;
            mis_r         <= 1'b0;
            oob_r         <= 1'b0;
            size_r        <= 2'b00;
            off_r         <= 2'b00;
            SRAM_addr_sel <= {SRAM_AW{1'b0}};
            SRAM_byte_sel <= 4'b0000;
            SRAM_dat_in   <= 32'h0000_0000;
            CU_dat_out    <= 32'h0000_0000;
        end else begin
            if (capture_s) begin
                we_r          <= CU_we;
                uns_r         <= CU_unsigned;
                mis_r         <= mis_s;
                oob_r         <= oob_s;
                size_r        <= CU_size;
                off_r         <= off_s;
                SRAM_addr_sel <= word_s[SRAM_AW-1:0];
                SRAM_byte_sel <= mask_s;
                SRAM_dat_in   <= CU_dat_in << {off_s, 3'b000};
            end
            if (data_done_s) begin
                CU_dat_out <= extend(SRAM_dat_out >> {off_r, 3'b000}, size_r, uns_r);
            end
        end
    end
endmodule

// File: tb/tb_mmu_lsu.sv
// Self-checking bench for mmu_lsu: directed vector table, corner sequences, random requests vs a byte-level model.
module tb_mmu_lsu;
    localparam int LAT   = 2;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'd0, din = 32'd0;
    logic [31:0] dout, sdin, sdout;
    logic        ready, mis, oob, rp, wp;
    logic [6:0]  asel;
    logic [3:0]  bsel;

    mmu_lsu #(.ADDR_W(32), .SRAM_DEPTH(DEPTH), .SRAM_LAT(LAT)) dut (
        .soc_clk(clk), .soc_rst(rst), .MMU_stall(stall), .MMU_flush(flush),
        .CU_req(req), .CU_we(we), .CU_size(size), .CU_unsigned(uns),
        .CU_address(addr), .CU_dat_in(din), .CU_dat_out(dout),
        .MMU_ready(ready), .MMU_misalign(mis), .MMU_oob(oob),
        .SRAM_addr_sel(asel), .SRAM_byte_sel(bsel), .SRAM_dat_in(sdin),
        .SRAM_dat_out(sdout), .read_pulse(rp), .write_pulse(wp)
    );

    // SRAM model: byte-lane writes, read data valid LAT cycles after the strobe cycle, garbage otherwise.
    logic [31:0] mem [DEPTH];
    logic [31:0] pipe [LAT];
    assign sdout = pipe[LAT-1];
    always @(posedge clk) begin
        if (wp) begin
            for (int i = 0; i < 4; i++)
                if (bsel[i]) mem[asel][8*i +: 8] <= sdin[8*i +: 8];
        end
        pipe[0] <= rp ? mem[asel] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        int          nstall;
        int          dstall;
        logic        mis;
        logic        oob;
        logic [3:0]  sel;
        logic [31:0] dsram;
        logic [6:0]  asel;
        logic [31:0] dout;
    } vec_t;

    int          checks = 0, failures = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] cur_dout = 32'd0;
    vec_t        tab [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                                input logic [31:0] d, input int ns, input int ds, input logic m,
                                input logic o, input logic [3:0] sl, input logic [31:0] dsr,
                                input logic [6:0] as, input logic [31:0] dq);
        vec_t v;
        v.we = w; v.size = sz; v.uns = u; v.addr = a; v.data = d; v.nstall = ns; v.dstall = ds;
        v.mis = m; v.oob = o; v.sel = sl; v.dsram = dsr; v.asel = as; v.dout = dq;
        return v;
    endfunction

    // Reference model: byte-addressed view of memory with arithmetic extension.
    function automatic vec_t model(input logic w, input logic [1:0] sz, input logic u,
                                   input logic [31:0] a, input logic [31:0] d, input int ns, input int ds);
        vec_t   v;
        int     off, nb;
        longint wi, val, lim;
        off = int'(a % 4);
        wi  = longint'(a) / 4;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v.we = w; v.size = sz; v.uns = u; v.addr = a; v.data = d; v.dstall = ds;
        v.mis    = (sz == 2'd3) || (off % nb != 0);
        v.oob    = (wi >= DEPTH);
        v.nstall = (v.mis || v.oob) ? 0 : ns;
        v.sel    = 4'(((1 << nb) - 1) << off);
        v.dsram  = d << (8 * off);
        v.asel   = 7'(wi % DEPTH);
        v.dout   = cur_dout;
        if (!v.mis && !v.oob && !w) begin
            val = longint'(ref_mem[wi] >> (8 * off));
            if (nb == 4) begin
                v.dout = 32'(val);
            end else begin
                lim = longint'(1) << (8 * nb);
                val = val % lim;
                if (!u && val >= lim / 2) val = val - lim;
                v.dout = 32'(val);
            end
        end
        return v;
    endfunction

    task automatic commit(input vec_t v);
        int off, nb;
        off = int'(v.addr % 4);
        nb  = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        if (v.we && !v.mis && !v.oob)
            for (int i = 0; i < nb; i++) ref_mem[v.addr / 4][8*(off+i) +: 8] = v.data[8*i +: 8];
        cur_dout = v.dout;
    endtask

    // One request from cycle 0 to the end of DONE, with timing, pulse, drive and result checks.
    task automatic do_req(input vec_t v);
        logic        err;
        int          exp_pc, exp_rc, rc, pc, npulse, badflag;
        logic        rd_seen, wr_seen;
        logic [3:0]  s_sel;
        logic [31:0] s_din;
        logic [6:0]  s_asel;
        err    = v.mis | v.oob;
        exp_pc = 1 + v.nstall;
        exp_rc = err ? 1 : (v.we ? 2 + v.nstall : 2 + LAT + v.nstall);
        rc = 0; pc = 0; npulse = 0; badflag = 0; rd_seen = 1'b0; wr_seen = 1'b0;
        s_sel = 4'd0; s_din = 32'd0; s_asel = 7'd0;
        @(negedge clk);
        req = 1'b1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; din = v.data;
        stall = 1'b0; flush = 1'b0;
        #1;
        chk("idle_quiet", {29'd0, ready, rp, wp}, 32'd0);
        for (int cyc = 1; cyc <= 40 && rc == 0; cyc++) begin
            @(negedge clk);
            req = 1'(($urandom % 2)); we = 1'($urandom % 2); size = 2'($urandom % 4);
            uns = 1'($urandom % 2); addr = $urandom; din = $urandom;
            stall = (cyc <= v.nstall) || (cyc >= exp_rc && cyc < exp_rc + v.dstall);
            #1;
            if (rp || wp) begin
                npulse++; pc = cyc; rd_seen = rp; wr_seen = wp;
                s_sel = bsel; s_din = sdin; s_asel = asel;
            end
            if (!ready && (mis || oob)) badflag = 1;
            if (ready) begin
                rc = cyc;
                chk("flags", {30'd0, mis, oob}, {30'd0, v.mis, v.oob});
                chk("dout", dout, v.dout);
            end
        end
        req = 1'b0;
        chk("ready_cycle", 32'(rc), 32'(exp_rc));
        chk("pulse_count", 32'(npulse), err ? 32'd0 : 32'd1);
        chk("flag_outside_done", 32'(badflag), 32'd0);
        if (!err) begin
            chk("pulse_cycle", 32'(pc), 32'(exp_pc));
            chk("pulse_kind", {30'd0, rd_seen, wr_seen}, v.we ? 32'd1 : 32'd2);
            chk("byte_sel", {28'd0, s_sel}, {28'd0, v.sel});
            chk("addr_sel", {25'd0, s_asel}, {25'd0, v.asel});
            if (v.we) chk("sram_din", s_din, v.dsram);
        end
        for (int k = 1; k <= v.dstall; k++) begin
            @(negedge clk);
            stall = (k < v.dstall);
            #1;
            chk("done_hold", {31'd0, ready}, 32'd1);
        end
        stall = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   np, nr;
        tab[0]  = mk(1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 0, 0, 0, 0, 4'hF, 32'hDEADBEEF, 7'd4, 32'h0);
        tab[1]  = mk(0, 2'd2, 0, 32'h10,  32'h0,        0, 0, 0, 0, 4'hF, 32'h0,        7'd4, 32'hDEADBEEF);
        tab[2]  = mk(1, 2'd2, 0, 32'h10,  32'h80FF7F01, 0, 0, 0, 0, 4'hF, 32'h80FF7F01, 7'd4, 32'hDEADBEEF);
        tab[3]  = mk(0, 2'd0, 0, 32'h13,  32'h0,        0, 0, 0, 0, 4'h8, 32'h0,        7'd4, 32'hFFFFFF80);
        tab[4]  = mk(0, 2'd0, 1, 32'h13,  32'h0,        0, 0, 0, 0, 4'h8, 32'h0,        7'd4, 32'h00000080);
        tab[5]  = mk(1, 2'd1, 0, 32'h22,  32'h1234,     0, 0, 0, 0, 4'hC, 32'h12340000, 7'd8, 32'h00000080);
        tab[6]  = mk(0, 2'd1, 0, 32'h22,  32'h0,        0, 0, 0, 0, 4'hC, 32'h0,        7'd8, 32'h00001234);
        tab[7]  = mk(0, 2'd1, 0, 32'h01,  32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        7'd0, 32'h00001234);
        tab[8]  = mk(0, 2'd2, 0, 32'h200, 32'h0,        0, 0, 0, 1, 4'h0, 32'h0,        7'd0, 32'h00001234);
        tab[9]  = mk(0, 2'd2, 0, 32'h10,  32'h0,        3, 0, 0, 0, 4'hF, 32'h0,        7'd4, 32'h80FF7F01);
        tab[10] = mk(0, 2'd1, 0, 32'h12,  32'h0,        0, 0, 0, 0, 4'hC, 32'h0,        7'd4, 32'hFFFF80FF);
        tab[11] = mk(1, 2'd3, 0, 32'h00,  32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        7'd0, 32'hFFFF80FF);
        tab[12] = mk(1, 2'd0, 0, 32'h11,  32'hAB,       0, 2, 0, 0, 4'h2, 32'h0000AB00, 7'd4, 32'hFFFF80FF);
        tab[13] = mk(0, 2'd2, 1, 32'h10,  32'h0,        1, 0, 0, 0, 4'hF, 32'h0,        7'd4, 32'h80FFAB01);
        tab[14] = mk(1, 2'd1, 0, 32'h201, 32'h5555,     0, 1, 1, 1, 4'h0, 32'h0,        7'd0, 32'h80FFAB01);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_dout", dout, 32'd0);
        chk("reset_ctl", {27'd0, ready, mis, oob, rp, wp}, 32'd0);
        chk("reset_sram", {21'd0, asel, bsel}, 32'd0);
        chk("reset_sdin", sdin, 32'd0);

        for (int i = 0; i < 15; i++) begin
            do_req(tab[i]);
            commit(tab[i]);
        end

        for (int i = 0; i < DEPTH; i++) begin
            v = model(1'b1, 2'd2, 1'b0, 32'(4 * i), (i == 5) ? 32'h1357_2468 : $urandom,
                      int'($urandom_range(0, 1)), 0);
            do_req(v);
            commit(v);
        end

        // Flush in the last WAIT cycle, with a busy CU_req that must be ignored.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h14; stall = 1'b0; flush = 1'b0;
        #1;
        np = 0; nr = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            req = (cyc == 2); addr = 32'h20; flush = (cyc == 1 + LAT);
            #1;
            np += int'(rp) + int'(wp);
            nr += int'(ready);
        end
        flush = 1'b0; req = 1'b0;
        chk("flush_wait_pulses", 32'(np), 32'd1);
        chk("flush_wait_ready", 32'(nr), 32'd0);
        chk("flush_wait_dout", dout, cur_dout);

        // Flush during a write ISSUE: the strobe still fires and the write commits.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h18; din = 32'hCAFEF00D;
        #1;
        @(negedge clk);
        req = 1'b0; flush = 1'b1;
        #1;
        chk("flush_issue_wp", {31'd0, wp}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_issue_ready", {31'd0, ready}, 32'd0);
        ref_mem[6] = 32'hCAFEF00D;
        v = model(1'b0, 2'd2, 1'b0, 32'h18, 32'd0, 0, 0);
        do_req(v);
        commit(v);

        // Reset in the middle of a read.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h14;
        #1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_dout", dout, 32'd0);
        chk("midrst_ctl", {27'd0, ready, mis, oob, rp, wp}, 32'd0);
        chk("midrst_sram", {21'd0, asel, bsel}, 32'd0);
        chk("midrst_sdin", sdin, 32'd0);
        cur_dout = 32'd0;

        for (int n = 0; n < 200; n++) begin
            v = model(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                      32'($urandom_range(0, 32'h21F)), $urandom,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
            do_req(v);
            commit(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
